// File: rtl/ledger_pkg.sv
// ledger_pkg: shared types and constants for the ledger ingress slice.
//   BPS_DENOM     - basis-point denominator; fees above it are illegal
//   opcode_e      - transaction opcode (transfer / swap)
//   ledger_tx_t   - queued transaction: payload plus the fees stamped at accept
//   fee_ok()      - legality check for a single fee value
package ledger_pkg;

  localparam int BPS_DENOM            = 10000;
  localparam int LEDGER_USER_WIDTH    = 10;
  localparam int LEDGER_BALANCE_WIDTH = 64;
  localparam int FEE_WIDTH            = 16;

  typedef enum logic {
    OP_TRANSFER = 1'b0,
    OP_SWAP     = 1'b1
  } opcode_e;

  typedef struct packed {
    opcode_e                         opcode;
    logic [LEDGER_USER_WIDTH-1:0]    user_a;
    logic [LEDGER_USER_WIDTH-1:0]    user_b;
    logic [LEDGER_BALANCE_WIDTH-1:0] amount_0;
    logic [LEDGER_BALANCE_WIDTH-1:0] amount_1;
    logic [FEE_WIDTH-1:0]            fee_bps0;
    logic [FEE_WIDTH-1:0]            fee_bps1;
  } ledger_tx_t;

  function automatic logic fee_ok(input logic [FEE_WIDTH-1:0] fee);
    return fee <= FEE_WIDTH'(BPS_DENOM);
  endfunction

endpackage

// File: rtl/ledger_tx_fifo.sv
// ledger_tx_fifo: synchronous FIFO of ledger_tx_t.
//   clk, rst       - clock, asynchronous active-high reset (empties the FIFO)
//   push_i, din_i  - write strobe and entry; caller must not push when full
//   pop_i, dout_o  - read strobe and head entry (dout_o valid while !empty_o)
//   full_o, empty_o, level_o - occupancy status
// The head is read straight from the array so the consumer can register it
// in the same cycle it pops; this keeps accept-to-issue at two edges.
module ledger_tx_fifo
  import ledger_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  ledger_tx_t               din_i,
  input  logic                     pop_i,
  output ledger_tx_t               dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  ledger_tx_t     mem_q [DEPTH];
  // One extra pointer bit tells full (MSBs differ) from empty (equal).
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;

  assign wr_ptr_d = push_i ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = pop_i  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (level_o == (AW+1)'(DEPTH));

endmodule

// File: rtl/ledger_ingress.sv
// ledger_ingress: client ingress for ledger_core.
//   clk, rst                         - clock, asynchronous active-high reset
//   cfg_wr, cfg_fee_bps_asset0/1     - fee config write; cfg_err pulses on a bad write
//   in_valid/in_ready, in_*          - client transaction handshake and payload
//   issue_en                         - host permission to issue to the core
//   s_valid, s_*                     - registered core input bus (no backpressure)
//   fifo_level                       - queued entries
//   accept_cnt, reject_cnt, issue_cnt - wrapping statistics
module ledger_ingress
  import ledger_pkg::*;
#(
  parameter int USER_WIDTH    = LEDGER_USER_WIDTH,
  parameter int BALANCE_WIDTH = LEDGER_BALANCE_WIDTH,
  parameter int FIFO_DEPTH    = 8,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_wr,
  input  logic [15:0]                  cfg_fee_bps_asset0,
  input  logic [15:0]                  cfg_fee_bps_asset1,
  output logic                         cfg_err,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_opcode,
  input  logic [USER_WIDTH-1:0]        in_user_a,
  input  logic [USER_WIDTH-1:0]        in_user_b,
  input  logic [BALANCE_WIDTH-1:0]     in_amount_0,
  input  logic [BALANCE_WIDTH-1:0]     in_amount_1,
  input  logic                         issue_en,
  output logic                         s_valid,
  output logic                         s_opcode,
  output logic [USER_WIDTH-1:0]        s_user_a,
  output logic [USER_WIDTH-1:0]        s_user_b,
  output logic [BALANCE_WIDTH-1:0]     s_amount_0,
  output logic [BALANCE_WIDTH-1:0]     s_amount_1,
  output logic [15:0]                  s_fee_bps_asset0,
  output logic [15:0]                  s_fee_bps_asset1,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [CNT_WIDTH-1:0]         accept_cnt,
  output logic [CNT_WIDTH-1:0]         reject_cnt,
  output logic [CNT_WIDTH-1:0]         issue_cnt
);

  logic [15:0] fee0_q, fee1_q;
  logic        cfg_err_q;
  logic        alive_q;     // low in reset and for the first cycle after, so in_ready starts at 0
  logic        s_valid_q;
  ledger_tx_t  s_tx_q;

  ledger_tx_t  in_tx, head_tx;
  logic        fifo_full, fifo_empty;
  logic        handshake, tx_ok, push, pop, cfg_bad;

  assign in_ready  = alive_q && !fifo_full;
  assign handshake = in_valid && in_ready;
  assign tx_ok     = (in_amount_0 != '0) && !(in_opcode && (in_amount_1 == '0));
  assign push      = handshake && tx_ok;
  // Pops only what was present before this edge, so a same-edge push is never issued.
  assign pop       = issue_en && !fifo_empty;
  assign cfg_bad   = !fee_ok(cfg_fee_bps_asset0) || !fee_ok(cfg_fee_bps_asset1);

  // Entries capture the pre-write fees even when cfg_wr lands on the same edge.
  always_comb begin
    in_tx          = '0;
    in_tx.opcode   = opcode_e'(in_opcode);
    in_tx.user_a   = in_user_a;
    in_tx.user_b   = in_user_b;
    in_tx.amount_0 = in_amount_0;
    in_tx.amount_1 = in_amount_1;
    in_tx.fee_bps0 = fee0_q;
    in_tx.fee_bps1 = fee1_q;
  end

  ledger_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (in_tx),
    .pop_i   (pop),
    .dout_o  (head_tx),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fee0_q    <= '0;
      fee1_q    <= '0;
      cfg_err_q <= 1'b0;
      alive_q   <= 1'b0;
      s_valid_q <= 1'b0;
      s_tx_q    <= '0;
    end else begin
      alive_q   <= 1'b1;
      cfg_err_q <= cfg_wr && cfg_bad;
      if (cfg_wr && !cfg_bad) begin
        fee0_q <= cfg_fee_bps_asset0;
        fee1_q <= cfg_fee_bps_asset1;
      end
      s_valid_q <= pop;
      if (pop) s_tx_q <= head_tx;
    end
  end

  // Statistics: 0 = accept, 1 = reject, 2 = issue.
  logic [2:0] cnt_inc;
  assign cnt_inc = {pop, handshake && !tx_ok, push};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)              cnt_q <= '0;
      else if (cnt_inc[gi]) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign accept_cnt = g_cnt[0].cnt_q;
  assign reject_cnt = g_cnt[1].cnt_q;
  assign issue_cnt  = g_cnt[2].cnt_q;

  assign cfg_err          = cfg_err_q;
  assign s_valid          = s_valid_q;
  assign s_opcode         = s_tx_q.opcode;
  assign s_user_a         = s_tx_q.user_a;
  assign s_user_b         = s_tx_q.user_b;
  assign s_amount_0       = s_tx_q.amount_0;
  assign s_amount_1       = s_tx_q.amount_1;
  assign s_fee_bps_asset0 = s_tx_q.fee_bps0;
  assign s_fee_bps_asset1 = s_tx_q.fee_bps1;

endmodule
